pcie_mwr_tx: RTL and testbench
==============================

// Module: pcie_mwr_tx
// PURPOSE
//  Posted memory-write TLP transmitter for the 16-bit VC0 TX port of the ECP3 PCIe core.
//  - It is the transmit-side counterpart of the receive and slave-bus path.
//  - User logic requests a write with a 32-bit address and a length of 1..MAX_LEN_DW dwords.
//  - The block checks posted credits, builds a 3DW MWr header and pulls payload words from a FWFT source.
//  - It streams the TLP on tx_data_vc0 using the core's req/rdy/st/end handshake.
// PARAMETERS
//  MAX_LEN_DW  32  largest accepted payload in dwords; legal range 1..128
// PORTS
//  pcie_clk     in   1   125 MHz core clock; the only clock
//  sys_rst      in   1   asynchronous, active-high reset
//  bus_num      in   8   requester ID, bus field
//  dev_num      in   5   requester ID, device field
//  func_num     in   3   requester ID, function field
//  wr_req       in   1   request strobe; sampled in IDLE only
//  wr_adr       in   32  byte address; bits [1:0] ignored
//  wr_len       in   8   payload dwords; 0 or >MAX_LEN_DW is rejected
//  wr_busy      out  1   high from request acceptance until tx_end is sent
//  wr_err       out  1   one-cycle pulse when a request is rejected
//  dat_rd       out  1   pop strobe; dat_in must be valid in the same cycle (FWFT)
//  dat_in       in   16  payload halfword; upper half of each dword first
//  tx_req       out  1   to tx_req_vc0
//  tx_rdy       in   1   from tx_rdy_vc0
//  tx_st        out  1   to tx_st_vc0
//  tx_end       out  1   to tx_end_vc0
//  tx_data      out  16  to tx_data_vc0
//  tx_ca_ph     in   9   posted header credits; bit 8 = infinite
//  tx_ca_pd     in   13  posted data credits (16 B units); bit 12 = infinite
//  tx_ca_p_recheck in 1  core request to re-evaluate posted credits
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-packet aborts at once; tx_end is not emitted.
//  States and transitions:
//  - IDLE: wr_req with legal wr_len -> latch adr/len, wr_busy=1 -> CREDIT.
//    wr_req with illegal wr_len -> wr_err pulse next cycle; stay IDLE.
//  - CREDIT: need ph>=1 and pd>=ceil(len/4), where bit 8 / bit 12 set means pass.
//    Pass -> REQ. Otherwise wait; the check repeats every cycle.
//  - REQ: tx_req=1 until tx_rdy is seen.
//    If tx_ca_p_recheck is high, credits fail, and tx_rdy is not yet seen: drop tx_req -> CREDIT.
//  - HDR: entered the cycle after the first tx_rdy. tx_req=0 in the same cycle.
//    6 halfwords, tx_st=1 on the first halfword only:
//      H0=16'h4000 (fmt=2'b10 MWr 3DW, type 0, TC 0)
//      H1={6'b0,len[9:0]} (TD=EP=0, attr 0; len zero-extended)
//      H2={bus,dev,func}
//      H3={8'h00 tag, lastBE, firstBE}; firstBE=4'hF; lastBE=4'hF if len>1 else 4'h0
//      H4=adr[31:16]
//      H5={adr[15:2],2'b00}
//  - DATA: 2*len halfwords. dat_rd=1 exactly when a halfword is driven and tx_rdy=1; tx_data=dat_in.
//    tx_end=1 on the final halfword.
//  - After the final halfword -> IDLE; wr_busy drops the cycle after tx_end.
//  Stalls:
//  - tx_rdy low in HDR/DATA: hold tx_data and the word index; tx_st, tx_end and dat_rd stay 0.
//    A stalled first word re-asserts tx_st when it is sent.
//  Width and arithmetic rules:
//  - Data-credit need is (len+3)>>2, computed in 7 bits.
//  - The word counter is 9 bits and counts down to 0; there is no wrap.
//  Simultaneous events:
//  - wr_req while busy is ignored; no error is raised.
//  - tx_ca_p_recheck after HDR has started is ignored; the packet completes.
//  Latency: wr_req to tx_req is 2 cycles with credits available; tx_rdy to tx_st is 1 cycle.
// STRUCTURE
//  Shared package pcie_tlp_pkg holds:
//  - TLP fmt/type constants (FMT_3DW_D=2'b10, TYPE_MEM=5'b00000).
//  - The header halfword index enum.
//  - The state encoding localparams.
//  One natural sub-module: pcie_p_credit_chk, a combinational credit compare with infinite-credit handling.
//  It is reusable by a later completion transmitter.
// TESTING
//  1. Credits infinite; wr_len=1, adr=32'h1234_5678, dat_in 16'hAAAA,16'h5555, bus/dev/func 8'h01/5'h00/3'h0:
//     -> 8 halfwords 4000,0001,0100,000F,1234,5678,AAAA,5555; tx_st on word 0, tx_end on word 7, 2 dat_rd pulses.
//  2. wr_len=4, tx_ca_pd=1 then 0 -> tx_req rises; with tx_ca_pd=0 -> no tx_req until pd>=1; H3=00FF, 14 halfwords total.
//  3. tx_rdy dropped for 3 cycles after word 5 of a len=2 packet -> tx_data holds, no dat_rd, correct resume, tx_end on word 9.
//  4. wr_len=0 and wr_len=MAX_LEN_DW+1 -> wr_err pulse, no tx_req, wr_busy stays 0.
//  5. Recheck in REQ with tx_ca_ph=0 -> tx_req drops; ph=1 -> retried and sent intact.
//  6. sys_rst asserted mid-DATA -> all outputs 0 immediately; next request after reset transmits a clean packet.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - TLP constants, header index and TX state encodings
package pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_D = 2'b10;
    localparam logic [4:0] TYPE_MEM  = 5'b00000;

    typedef enum logic [2:0] {
        HW_0 = 3'd0,
        HW_1 = 3'd1,
        HW_2 = 3'd2,
        HW_3 = 3'd3,
        HW_4 = 3'd4,
        HW_5 = 3'd5
    } hdr_idx_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CREDIT = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_HDR    = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CREDIT = ST_CREDIT,
        REQ    = ST_REQ,
        HDR    = ST_HDR,
        DATA   = ST_DATA
    } tx_state_e;

    // Posted data credits are 16-byte units, i.e. four dwords each.
    function automatic logic [6:0] pd_need(input logic [7:0] len_dw);
        logic [8:0] sum;
        sum = {1'b0, len_dw} + 9'd3;
        return sum[8:2];
    endfunction

endpackage

// File: rtl/pcie_p_credit_chk.sv
// rtl/pcie_p_credit_chk.sv - posted header/data credit compare with infinite-credit handling
module pcie_p_credit_chk (
    input  logic [8:0]  ca_ph,
    input  logic [12:0] ca_pd,
    input  logic [6:0]  need_pd,
    output logic        ok
);

    logic ph_ok;
    logic pd_ok;

    // The top bit of each credit field advertises infinite credit.
    assign ph_ok = ca_ph[8]  || (ca_ph[7:0] != 8'd0);
    assign pd_ok = ca_pd[12] || (ca_pd[11:0] >= {5'd0, need_pd});
    assign ok    = ph_ok && pd_ok;

endmodule

// File: rtl/pcie_mwr_tx.sv
// rtl/pcie_mwr_tx.sv - posted MWr TLP transmitter for the 16-bit VC0 TX port
module pcie_mwr_tx
    import pcie_tlp_pkg::*;
#(
    parameter int MAX_LEN_DW = 32
) (
    input  logic        pcie_clk,
    input  logic        sys_rst,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    input  logic        wr_req,
    input  logic [31:0] wr_adr,
    input  logic [7:0]  wr_len,
    output logic        wr_busy,
    output logic        wr_err,
    output logic        dat_rd,
    input  logic [15:0] dat_in,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    input  logic [8:0]  tx_ca_ph,
    input  logic [12:0] tx_ca_pd,
    input  logic        tx_ca_p_recheck
);

    tx_state_e   state;
    tx_state_e   state_n;
    hdr_idx_e    hidx;
    logic [7:0]  len_q;
    logic [31:0] adr_q;
    logic [8:0]  cnt;
    logic        len_ok;
    logic        credit_ok;
    logic [3:0]  last_be;
    logic [15:0] hdr_word;

    assign len_ok  = (wr_len != 8'd0) && (int'(wr_len) <= MAX_LEN_DW);
    assign last_be = (len_q > 8'd1) ? 4'hF : 4'h0;
    assign wr_busy = (state != IDLE);

    pcie_p_credit_chk u_credit (
        .ca_ph   (tx_ca_ph),
        .ca_pd   (tx_ca_pd),
        .need_pd (pd_need(len_q)),
        .ok      (credit_ok)
    );

    always_comb begin
        hdr_word = 16'h0000;
        case (hidx)
            HW_0:    hdr_word = {1'b0, FMT_3DW_D, TYPE_MEM, 1'b0, 3'b000, 4'b0000};
            HW_1:    hdr_word = {6'b0, 2'b00, len_q};
            HW_2:    hdr_word = {bus_num, dev_num, func_num};
            HW_3:    hdr_word = {8'h00, last_be, 4'hF};
            HW_4:    hdr_word = adr_q[31:16];
            HW_5:    hdr_word = adr_q[15:0];
            default: hdr_word = 16'h0000;
        endcase
    end

    always_comb begin
        state_n = state;
        tx_req  = 1'b0;
        tx_st   = 1'b0;
        tx_end  = 1'b0;
        dat_rd  = 1'b0;
        tx_data = 16'h0000;
        case (state)
            IDLE: begin
                if (wr_req && len_ok) state_n = CREDIT;
            end
            CREDIT: begin
                if (credit_ok) state_n = REQ;
            end
            REQ: begin
                tx_req = 1'b1;
                if (tx_rdy)
                    state_n = HDR;
                else if (tx_ca_p_recheck && !credit_ok)
                    state_n = CREDIT;
            end
            HDR: begin
                tx_data = hdr_word;
                tx_st   = tx_rdy && (hidx == HW_0);
                if (tx_rdy && (hidx == HW_5)) state_n = DATA;
            end
            DATA: begin
                // FWFT source: dat_in already holds the word that dat_rd pops.
                tx_data = dat_in;
                dat_rd  = tx_rdy;
                tx_end  = tx_rdy && (cnt == 9'd0);
                if (tx_rdy && (cnt == 9'd0)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            hidx   <= HW_0;
            len_q  <= 8'd0;
            adr_q  <= 32'd0;
            cnt    <= 9'd0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_n;
            wr_err <= (state == IDLE) && wr_req && !len_ok;
            if ((state == IDLE) && wr_req && len_ok) begin
                len_q <= wr_len;
                adr_q <= wr_adr & ~32'h3;
            end
            if ((state == HDR) && tx_rdy) begin
                if (hidx == HW_5) begin
                    hidx <= HW_0;
                    cnt  <= {len_q, 1'b0} - 9'd1;
                end else begin
                    hidx <= hdr_idx_e'(hidx + 3'd1);
                end
            end
            if ((state == DATA) && tx_rdy && (cnt != 9'd0))
                cnt <= cnt - 9'd1;
        end
    end

endmodule

// File: tb/tb_pcie_mwr_tx.sv
// tb/tb_pcie_mwr_tx.sv - scoreboard bench for pcie_mwr_tx
module tb_pcie_mwr_tx;

    logic        pcie_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic        wr_req;
    logic [31:0] wr_adr;
    logic [7:0]  wr_len;
    logic        wr_busy;
    logic        wr_err;
    logic        dat_rd;
    logic [15:0] dat_in;
    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;
    logic [8:0]  tx_ca_ph;
    logic [12:0] tx_ca_pd;
    logic        tx_ca_p_recheck;

    pcie_mwr_tx #(.MAX_LEN_DW(32)) dut (
        .pcie_clk        (pcie_clk),
        .sys_rst         (sys_rst),
        .bus_num         (bus_num),
        .dev_num         (dev_num),
        .func_num        (func_num),
        .wr_req          (wr_req),
        .wr_adr          (wr_adr),
        .wr_len          (wr_len),
        .wr_busy         (wr_busy),
        .wr_err          (wr_err),
        .dat_rd          (dat_rd),
        .dat_in          (dat_in),
        .tx_req          (tx_req),
        .tx_rdy          (tx_rdy),
        .tx_st           (tx_st),
        .tx_end          (tx_end),
        .tx_data         (tx_data),
        .tx_ca_ph        (tx_ca_ph),
        .tx_ca_pd        (tx_ca_pd),
        .tx_ca_p_recheck (tx_ca_p_recheck)
    );

    always #4 pcie_clk = ~pcie_clk;

    typedef struct {
        logic [15:0] data;
        logic        st;
        logic        en;
        logic        rd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          in_pkt = 1'b0;
    logic [15:0] pay [0:255];
    int          pops     = 0;
    int          pay_base = 0;

    assign dat_in = pay[8'(pops - pay_base)];

    always @(posedge pcie_clk) if (dat_rd) pops <= pops + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input logic st, input logic en, input logic rd);
        exp_t e;
        e.data = d; e.st = st; e.en = en; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic push_hdr(input logic [15:0] h1, input logic [15:0] h2, input logic [15:0] h3,
                            input logic [15:0] h4, input logic [15:0] h5);
        push_word(16'h4000, 1'b1, 1'b0, 1'b0);
        push_word(h1, 1'b0, 1'b0, 1'b0);
        push_word(h2, 1'b0, 1'b0, 1'b0);
        push_word(h3, 1'b0, 1'b0, 1'b0);
        push_word(h4, 1'b0, 1'b0, 1'b0);
        push_word(h5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) push_word(pay[i], 1'b0, (i == n - 1), 1'b1);
    endtask

    task automatic issue_req(input logic [7:0] len, input logic [31:0] adr);
        wr_len   = len;
        wr_adr   = adr;
        pay_base = pops;
        wr_req   = 1'b1;
        @(posedge pcie_clk); #1;
        wr_req   = 1'b0;
    endtask

    task automatic wait_req(output int lat);
        lat = 1;
        while (!tx_req && lat < 60) begin
            @(posedge pcie_clk); #1;
            lat++;
        end
        if (!tx_req) chk("tx_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_pkt(input int total, input int stall_at, input int stall_len);
        int sent;
        int stl;
        int guard;
        sent = 0; stl = stall_len; guard = 0;
        tx_rdy = 1'b1;
        @(posedge pcie_clk); #1;
        while (sent < total && guard < 1000) begin
            if (sent == stall_at && stl > 0) begin
                tx_rdy = 1'b0;
                stl--;
            end else begin
                tx_rdy = 1'b1;
                sent++;
            end
            @(posedge pcie_clk); #1;
            guard++;
        end
        tx_rdy = 1'b0;
        chk("pkt_busy_drop", {31'd0, wr_busy}, 32'd0);
        chk("pkt_drained", exp_q.size(), 32'd0);
    endtask

    always @(negedge pcie_clk) begin
        exp_t e;
        if (mon_en) begin
            if (in_pkt && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, tx_data}, 32'hFFFF_FFFF);
                    in_pkt = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", {16'd0, tx_data}, {16'd0, e.data});
                    chk("tx_st",   {31'd0, tx_st},   {31'd0, e.st});
                    chk("tx_end",  {31'd0, tx_end},  {31'd0, e.en});
                    chk("dat_rd",  {31'd0, dat_rd},  {31'd0, e.rd});
                    if (e.en) in_pkt = 1'b0;
                end
            end else if (in_pkt) begin
                chk("stall_ctl", {29'd0, tx_st, tx_end, dat_rd}, 32'd0);
                if (exp_q.size() != 0) chk("stall_hold", {16'd0, tx_data}, {16'd0, exp_q[0].data});
            end else begin
                chk("idle_ctl", {29'd0, tx_st, tx_end, dat_rd}, 32'd0);
            end
            if (tx_req && tx_rdy) in_pkt = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        sys_rst = 1'b1; wr_req = 1'b0; wr_adr = 32'd0; wr_len = 8'd0; tx_rdy = 1'b0;
        bus_num = 8'h01; dev_num = 5'h00; func_num = 3'h0;
        tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000; tx_ca_p_recheck = 1'b0;
        for (int i = 0; i < 256; i++) pay[i] = 16'h0000;
        repeat (3) @(posedge pcie_clk); #1;
        chk("rst_ctl", {26'd0, tx_req, tx_st, tx_end, dat_rd, wr_busy, wr_err}, 32'd0);
        chk("rst_data", {16'd0, tx_data}, 32'd0);
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        @(posedge pcie_clk); #1;

        // 1: minimal packet, infinite credits
        pay[0] = 16'hAAAA; pay[1] = 16'h5555;
        push_hdr(16'h0001, 16'h0100, 16'h000F, 16'h1234, 16'h5678);
        push_data(2);
        issue_req(8'd1, 32'h1234_5678);
        chk("t1_busy", {31'd0, wr_busy}, 32'd1);
        wait_req(lat);
        chk("t1_req_latency", lat, 32'd2);
        run_pkt(8, 99, 0);

        // 2: finite data credits hold the request until pd covers the need
        bus_num = 8'hA5; dev_num = 5'h1B; func_num = 3'h6;
        tx_ca_ph = 9'd1; tx_ca_pd = 13'd0;
        for (int i = 0; i < 8; i++) pay[i] = 16'h1000 + 16'(i);
        push_hdr(16'h0004, 16'hA5DE, 16'h00FF, 16'hDEAD, 16'hBEEC);
        push_data(8);
        issue_req(8'd4, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("t2_no_req", {31'd0, tx_req}, 32'd0);
            @(posedge pcie_clk); #1;
        end
        tx_ca_pd = 13'd1;
        wait_req(lat);
        run_pkt(14, 99, 0);
        bus_num = 8'h01; dev_num = 5'h00; func_num = 3'h0;
        tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000;

        // 3: tx_rdy stall after word 5
        pay[0] = 16'hC0DE; pay[1] = 16'hBEEF; pay[2] = 16'h1357; pay[3] = 16'h2468;
        push_hdr(16'h0002, 16'h0100, 16'h00FF, 16'h0000, 16'h1000);
        push_data(4);
        issue_req(8'd2, 32'h0000_1003);
        wait_req(lat);
        run_pkt(10, 6, 3);

        // 4: illegal lengths rejected, largest legal length accepted
        issue_req(8'd0, 32'h0000_0100);
        chk("t4_err0", {29'd0, wr_err, wr_busy, tx_req}, 32'h4);
        @(posedge pcie_clk); #1;
        chk("t4_err0_clr", {29'd0, wr_err, wr_busy, tx_req}, 32'h0);
        issue_req(8'd33, 32'h0000_0100);
        chk("t4_err33", {29'd0, wr_err, wr_busy, tx_req}, 32'h4);
        @(posedge pcie_clk); #1;
        chk("t4_err33_clr", {29'd0, wr_err, wr_busy, tx_req}, 32'h0);
        for (int i = 0; i < 64; i++) pay[i] = {8'(i), 8'(~i)};
        push_hdr(16'h0020, 16'h0100, 16'h00FF, 16'hFFFF, 16'hFFFC);
        push_data(64);
        issue_req(8'd32, 32'hFFFF_FFFF);
        chk("t4_max_no_err", {31'd0, wr_err}, 32'd0);
        wait_req(lat);
        run_pkt(70, 99, 0);

        // 5: recheck with failing header credits withdraws the request
        tx_ca_ph = 9'd1;
        pay[0] = 16'h1111; pay[1] = 16'h2222;
        push_hdr(16'h0001, 16'h0100, 16'h000F, 16'h0000, 16'h0040);
        push_data(2);
        issue_req(8'd1, 32'h0000_0040);
        wait_req(lat);
        tx_ca_ph = 9'd0; tx_ca_p_recheck = 1'b1;
        @(posedge pcie_clk); #1;
        tx_ca_p_recheck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_req_drop", {31'd0, tx_req}, 32'd0);
            @(posedge pcie_clk); #1;
        end
        tx_ca_ph = 9'd1;
        wait_req(lat);
        run_pkt(8, 99, 0);
        tx_ca_ph = 9'h100;

        // 6: reset mid-DATA, then a clean packet
        mon_en = 1'b0;
        for (int i = 0; i < 8; i++) pay[i] = 16'h7700 + 16'(i);
        issue_req(8'd4, 32'h0000_0100);
        wait_req(lat);
        tx_rdy = 1'b1;
        repeat (9) begin @(posedge pcie_clk); #1; end
        chk("t6_in_data", {31'd0, dat_rd}, 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_ctl", {26'd0, tx_req, tx_st, tx_end, dat_rd, wr_busy, wr_err}, 32'd0);
        chk("t6_rst_data", {16'd0, tx_data}, 32'd0);
        @(posedge pcie_clk); #1;
        sys_rst = 1'b0; tx_rdy = 1'b0;
        in_pkt = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge pcie_clk); #1;
        pay[0] = 16'h0F0F; pay[1] = 16'hF0F0;
        push_hdr(16'h0001, 16'h0100, 16'h000F, 16'h0000, 16'h0008);
        push_data(2);
        issue_req(8'd1, 32'h0000_0008);
        wait_req(lat);
        run_pkt(8, 99, 0);

        repeat (2) @(posedge pcie_clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
